// File: rtl/imem_program_loader.sv
`default_nettype none
// =============================================================================
// Module   : imem_program_loader
// Purpose  : Packs a host byte stream into big-endian 16-bit instruction words,
//            writes them from address 0 and holds the CPU in reset until done.
// Option   : IMEM_LOADER_OPCODE_CHECK_EN rejects words with opcode 4'hB / 4'hE.
// Revision : 1.0 - initial release
// =============================================================================
module imem_program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [15:0]       imem_wdata_q, imem_wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic        xfer;
  logic [15:0] lo_word;
  logic        lo_bad;
  logic        wr_bad;

  assign xfer    = byte_valid && byte_ready_q;
  assign lo_word = {hi_q, byte_data};

`ifdef IMEM_LOADER_OPCODE_CHECK_EN
  // lo_bad gates the strobe as WR is entered; wr_bad steers WR itself to ERR
  assign lo_bad = (lo_word[15:12] == 4'hB) || (lo_word[15:12] == 4'hE);
  assign wr_bad = (imem_wdata_q[15:12] == 4'hB) || (imem_wdata_q[15:12] == 4'hE);
`else
  assign lo_bad = 1'b0;
  assign wr_bad = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    last_d       = last_q;
    addr_d       = addr_q;
    count_d      = count_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = done_q;
    error_d      = error_q;
    imem_we_d    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HI;
          addr_d  = '0;
          count_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d = byte_data;
          if (byte_last) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (xfer) begin
          last_d       = byte_last;
          imem_addr_d  = addr_q;
          imem_wdata_d = lo_word;
          imem_we_d    = !lo_bad;
          state_d      = S_WR;
        end
      end
      S_WR: begin
        if (wr_bad) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          count_d = count_q + (ADDR_W+1)'(1);
          addr_d  = addr_q + ADDR_W'(1);
          if (last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (addr_q == LAST_ADDR) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_HI;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it
    byte_ready_d = (state_d == S_HI) || (state_d == S_LO);
    busy_d       = byte_ready_d || (state_d == S_WR);
    cpu_hold_d   = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hi_q         <= '0;
      last_q       <= 1'b0;
      addr_q       <= '0;
      count_q      <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = count_q;
  assign cpu_hold   = cpu_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// =============================================================================
// Module   : tb_imem_program_loader
// Purpose  : Drives byte programs into imem_program_loader and compares the
//            resulting writes and status against a word-level reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_imem_program_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_LOADER_OPCODE_CHECK_EN
  localparam bit OPC_CHECK = 1'b1;
`else
  localparam bit OPC_CHECK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_last = 1'b0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;
  logic              cpu_hold;

  imem_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  prog_q[$];   // {last, data}
  logic [23:0] wr_q[$];     // observed {addr, data}
  logic [23:0] exp_q[$];    // expected {addr, data}
  int          acc_bytes = 0;
  int          sent_bytes = 0;
  bit          prev_lo = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observer: samples mid low-phase; inputs are driven on the falling edge
  always @(negedge clk) begin
    #2;
    if (imem_we) begin
      check_val("we_one_cycle_after_lo_xfer", {31'd0, prev_lo}, 32'd1);
      check_val("ready_low_during_wr", {31'd0, byte_ready}, 32'd0);
      wr_q.push_back({imem_addr, imem_wdata});
    end
    if (byte_valid && byte_ready) begin
      acc_bytes++;
      prev_lo = (acc_bytes % 2 == 0);
    end else begin
      prev_lo = 1'b0;
    end
  end

  // Word-level model: pair bytes, apply last / odd / opcode / overflow rules
  task automatic run_model(output bit e_done, output bit e_err, output int e_acc);
    int         i;
    int         a;
    logic [7:0] hi;
    logic [8:0] lo;
    i = 0; a = 0; e_done = 1'b0; e_err = 1'b0; e_acc = 0;
    exp_q.delete();
    while (i < prog_q.size()) begin
      hi = prog_q[i][7:0];
      e_acc++;
      if (prog_q[i][8]) begin e_err = 1'b1; break; end
      i++;
      if (i >= prog_q.size()) break;
      lo = prog_q[i];
      i++;
      e_acc++;
      if (OPC_CHECK && (hi[7:4] == 4'hB || hi[7:4] == 4'hE)) begin e_err = 1'b1; break; end
      exp_q.push_back({a[ADDR_W-1:0], hi, lo[7:0]});
      a++;
      if (lo[8]) begin e_done = 1'b1; break; end
      if (a == DEPTH) begin e_err = 1'b1; break; end
    end
  endtask

  task automatic check_reset_vals();
    check_val("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check_val("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check_val("rst_imem_addr", 32'(imem_addr), 32'd0);
    check_val("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_error", {31'd0, error}, 32'd0);
    check_val("rst_word_count", 32'(word_count), 32'd0);
    check_val("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
  endtask

  task automatic do_load(input bit byte_on_start, input int gmin, input int gmax, input bit poke);
    bit e_done;
    bit e_err;
    int e_acc;
    int waited;
    int gap;
    bit gave_up;
    wr_q.delete();
    acc_bytes = 0; sent_bytes = 0; gave_up = 1'b0;
    @(negedge clk);
    check_val("ready_low_before_start", {31'd0, byte_ready}, 32'd0);
    start = 1'b1;
    if (byte_on_start && prog_q.size() > 0) begin
      byte_valid = 1'b1; byte_data = prog_q[0][7:0]; byte_last = prog_q[0][8];
    end
    @(negedge clk);
    start = 1'b0;
    check_val("start_error_cleared", {31'd0, error}, 32'd0);
    check_val("start_done_cleared", {31'd0, done}, 32'd0);
    check_val("start_busy", {31'd0, busy}, 32'd1);
    check_val("start_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check_val("start_word_count", 32'(word_count), 32'd0);
    foreach (prog_q[k]) begin
      if (gave_up) break;
      gap = (k == 0 && byte_on_start) ? 0 : int'($urandom_range(gmax, gmin));
      if (gap > 0) begin
        byte_valid = 1'b0;
        start = poke;
        @(negedge clk);
        start = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
      byte_valid = 1'b1; byte_data = prog_q[k][7:0]; byte_last = prog_q[k][8];
      waited = 0;
      while (!byte_ready && waited < 6) begin
        @(negedge clk);
        waited++;
      end
      if (byte_ready) begin
        @(negedge clk);
        sent_bytes++;
      end else begin
        gave_up = 1'b1;
      end
    end
    byte_valid = 1'b0; byte_last = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    run_model(e_done, e_err, e_acc);
    check_val("bytes_accepted", 32'(sent_bytes), 32'(e_acc));
    check_val("bytes_seen", 32'(acc_bytes), 32'(e_acc));
    check_val("end_done", {31'd0, done}, {31'd0, e_done});
    check_val("end_error", {31'd0, error}, {31'd0, e_err});
    check_val("end_busy", {31'd0, busy}, 32'd0);
    check_val("end_cpu_hold", {31'd0, cpu_hold}, {31'd0, !e_done});
    check_val("end_word_count", 32'(word_count), 32'(exp_q.size()));
    check_val("write_count", 32'(wr_q.size()), 32'(exp_q.size()));
    foreach (exp_q[j]) begin
      if (j < wr_q.size()) check_val("write_addr_data", 32'(wr_q[j]), 32'(exp_q[j]));
    end
  endtask

  function automatic logic [7:0] safe_hi();
    logic [7:0] b;
    b = 8'($urandom);
    if (b[7:4] == 4'hB || b[7:4] == 4'hE) b[7:4] = 4'h1;
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    bit odd;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    prog_q = '{9'h0F5, 9'h110};
    do_load(1'b0, 0, 0, 1'b0);

    prog_q = '{9'h006, 9'h012, 9'h032, 9'h060, 9'h0A0, 9'h115};
    do_load(1'b0, 2, 2, 1'b1);

    prog_q = '{9'h180};
    do_load(1'b0, 0, 0, 1'b0);

    prog_q = '{9'h0B0, 9'h100};
    do_load(1'b1, 0, 1, 1'b0);

    prog_q = '{9'h0E1, 9'h023, 9'h045, 9'h167};
    do_load(1'b0, 0, 2, 1'b0);

    // Overflow: one word more than depth, no last marker
    prog_q.delete();
    for (int w = 0; w < DEPTH + 1; w++) begin
      prog_q.push_back({1'b0, safe_hi()});
      prog_q.push_back({1'b0, 8'($urandom)});
    end
    do_load(1'b0, 0, 1, 1'b0);

    // Full depth with last on the final word
    prog_q.delete();
    for (int w = 0; w < DEPTH; w++) begin
      prog_q.push_back({1'b0, safe_hi()});
      prog_q.push_back({w == DEPTH - 1, 8'($urandom)});
    end
    do_load(1'b0, 0, 0, 1'b0);

    // Reset mid-word: high byte accepted, then reset
    wr_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'hC3; byte_last = 1'b0;
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("no_write_after_reset", 32'(wr_q.size()), 32'd0);
    prog_q = '{9'h07E, 9'h100};
    do_load(1'b0, 0, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      nw  = int'($urandom_range(8, 1));
      odd = ($urandom_range(9, 0) == 0);
      prog_q.delete();
      for (int w = 0; w < nw; w++) begin
        prog_q.push_back({1'b0, 8'($urandom)});
        prog_q.push_back({(w == nw - 1) && !odd, 8'($urandom)});
      end
      if (odd) prog_q.push_back({1'b1, 8'($urandom)});
      do_load(1'($urandom_range(1, 0)), 0, 3, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
